// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-requester data-memory arbiter: FSM encoding,
// requester IDs and the legal bounds of the memory latency.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LDR  = 1'b1;

  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 15;

endpackage

// File: rtl/dmem_arbiter_arb2_pick.sv
// Combinational 2-way winner selection between core and loader.
// DMEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise the core has fixed priority.
module arb2_pick
  import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  input  logic last_winner,
`endif
  input  logic c_req,
  input  logic l_req,
  output logic any,
  output logic winner
);

  // Pick one requester; on a tie the policy decides.
  always_comb begin
    any    = c_req | l_req;
    winner = REQ_CORE;
    if (c_req && l_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      winner = ~last_winner;
`else
      winner = REQ_CORE;
`endif
    end else if (l_req) begin
      winner = REQ_LDR;
    end else begin
      winner = REQ_CORE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates a core and a loader onto a single data-memory port, one transaction at a time.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN enables round-robin tie-breaking.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_done,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_done,
  output logic [DW-1:0] l_rdata,
  output logic          m_re,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          core_stall,
  output logic          busy
);

  // Out-of-range latencies are clamped so the 4-bit counter stays meaningful.
  localparam logic [3:0] LAT = (MEM_LAT < MEM_LAT_MIN) ? 4'(MEM_LAT_MIN) :
                               (MEM_LAT > MEM_LAT_MAX) ? 4'(MEM_LAT_MAX) : 4'(MEM_LAT);

  state_t        state_r, state_s;
  logic [3:0]    cnt_r;
  logic          win_r, we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r, c_rdata_r, l_rdata_r;
  logic          any_s, pick_s, in_access_s, last_cycle_s;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_winner_r;

  // Remember who was granted last; the loader is treated as last winner out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_winner_r <= REQ_LDR;
    end else if (state_r == ST_IDLE && any_s) begin
      last_winner_r <= pick_s;
    end
  end
`endif

  arb2_pick u_pick (
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    .last_winner (last_winner_r),
`endif
    .c_req       (c_req),
    .l_req       (l_req),
    .any         (any_s),
    .winner      (pick_s)
  );

  assign in_access_s  = (state_r == ST_ACCESS);
  assign last_cycle_s = in_access_s && (cnt_r == 4'd1);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_s) state_s = ST_ACCESS;
        else       state_s = ST_IDLE;
      end
      ST_ACCESS: begin
        if (cnt_r == 4'd1) state_s = ST_DONE;
        else               state_s = ST_ACCESS;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Latch the winning request, count the access and capture read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r     <= 4'd0;
      win_r     <= REQ_CORE;
      we_r      <= 1'b0;
      addr_r    <= {AW{1'b0}};
      wdata_r   <= {DW{1'b0}};
      c_rdata_r <= {DW{1'b0}};
      l_rdata_r <= {DW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            win_r   <= pick_s;
            we_r    <= (pick_s == REQ_LDR) ? l_we    : c_we;
            addr_r  <= (pick_s == REQ_LDR) ? l_addr  : c_addr;
            wdata_r <= (pick_s == REQ_LDR) ? l_wdata : c_wdata;
            cnt_r   <= LAT;
          end
        end
        ST_ACCESS: begin
          cnt_r <= cnt_r - 4'd1;
          if (last_cycle_s && !we_r) begin
            if (win_r == REQ_LDR) l_rdata_r <= m_rdata;
            else                  c_rdata_r <= m_rdata;
          end
        end
        ST_DONE: cnt_r <= 4'd0;
        default: cnt_r <= 4'd0;
      endcase
    end
  end

  // All outputs decode registered state only, except core_stall which follows c_req.
  assign c_gnt   = in_access_s && (cnt_r == LAT) && (win_r == REQ_CORE);
  assign l_gnt   = in_access_s && (cnt_r == LAT) && (win_r == REQ_LDR);
  assign c_done  = (state_r == ST_DONE) && (win_r == REQ_CORE);
  assign l_done  = (state_r == ST_DONE) && (win_r == REQ_LDR);
  assign c_rdata = c_rdata_r;
  assign l_rdata = l_rdata_r;
  assign m_re    = in_access_s && !we_r;
  assign m_we    = in_access_s && we_r;
  assign m_addr  = in_access_s ? addr_r  : {AW{1'b0}};
  assign m_wdata = in_access_s ? wdata_r : {DW{1'b0}};
  assign core_stall = c_req && !c_done;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter (MEM_LAT = 2): stimulus pushes expected grants/completions,
// a monitor pops and compares whenever the DUT shows a grant, memory access or done.
module tb_dmem_arbiter;

  localparam int LAT = 2;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        c_req, c_we, l_req, l_we;
  logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
  logic        c_gnt, c_done, l_gnt, l_done;
  logic [31:0] c_rdata, l_rdata;
  logic        m_re, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        core_stall, busy;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit          id;
    int          cy;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] c_rd;
    logic [31:0] l_rd;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];
  bit          tb_last = 1'b1;
  logic [31:0] mc = 32'h0;
  logic [31:0] ml = 32'h0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_5A5A);
  endfunction

  assign m_rdata = mem_f(m_addr);

  dmem_arbiter #(.MEM_LAT(LAT), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .core_stall(core_stall), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare grants, bus activity and completions against the queues.
  exp_t cur;
  int   acc_left = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        gq.delete();
        dq.delete();
        acc_left = 0;
      end else begin
        if (c_gnt && l_gnt) chk("double_gnt", 32'd1, 32'd0);
        else if (c_gnt || l_gnt) begin
          if (gq.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
          else begin
            cur = gq.pop_front();
            chk("gnt_id", {31'b0, l_gnt}, {31'b0, cur.id});
            chk("gnt_cycle", 32'(cyc), 32'(cur.cy));
            acc_left = LAT;
          end
        end
        if (m_re || m_we) begin
          if (acc_left == 0) chk("acc_extra", 32'd1, 32'd0);
          else begin
            chk("m_we", {31'b0, m_we}, {31'b0, cur.we});
            chk("m_re", {31'b0, m_re}, {31'b0, !cur.we});
            chk("m_addr", m_addr, cur.addr);
            chk("m_wdata", m_wdata, cur.we ? cur.wdata : 32'h0 | cur.wdata);
            acc_left--;
          end
        end else begin
          chk("idle_bus", m_addr | m_wdata, 32'h0);
        end
        if (c_done && l_done) chk("double_done", 32'd1, 32'd0);
        else if (c_done || l_done) begin
          if (dq.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
          else begin
            exp_t e;
            e = dq.pop_front();
            chk("done_id", {31'b0, l_done}, {31'b0, e.id});
            chk("done_cycle", 32'(cyc), 32'(e.cy));
            chk("acc_len", 32'(acc_left), 32'd0);
            chk("c_rdata", c_rdata, e.c_rd);
            chk("l_rdata", l_rdata, e.l_rd);
          end
        end
      end
    end
  end

  // Issue one or two simultaneous requests; each requester drops req when it sees done.
  task automatic issue(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit lr, input bit lw, input logic [31:0] la, input logic [31:0] ld,
                       input int drop);
    bit   order [2];
    int   n, c0, cdone, base;
    exp_t e;
    @(negedge clk); #1;
    c0 = cyc; n = 0; cdone = -1;
    if (cr && lr) begin
      n = 2;
      if (!RR || tb_last) begin order[0] = 1'b0; order[1] = 1'b1; end
      else                begin order[0] = 1'b1; order[1] = 1'b0; end
    end else if (cr) begin n = 1; order[0] = 1'b0; end
    else if (lr)     begin n = 1; order[0] = 1'b1; end
    for (int i = 0; i < n; i++) begin
      base    = c0 + i * (LAT + 2);
      e.id    = order[i];
      e.we    = e.id ? lw : cw;
      e.addr  = e.id ? la : ca;
      e.wdata = e.id ? ld : cd;
      if (!e.we) begin
        if (e.id) ml = mem_f(e.addr);
        else      mc = mem_f(e.addr);
      end
      e.c_rd = mc;
      e.l_rd = ml;
      e.cy   = base + 1;
      gq.push_back(e);
      e.cy   = base + 1 + LAT;
      dq.push_back(e);
      tb_last = e.id;
      if (!e.id) cdone = e.cy;
    end
    c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
    l_req = lr; l_we = lw; l_addr = la; l_wdata = ld;
    for (int k = 0; k < n * (LAT + 2) + 2; k++) begin
      @(negedge clk);
      chk("core_stall", {31'b0, core_stall}, {31'b0, c_req && (cyc < cdone)});
      #1;
      if (c_done) c_req = 1'b0;
      if (l_done) l_req = 1'b0;
      if (cyc == c0 + drop) c_req = 1'b0;
    end
  endtask

  initial begin
    exp_t e;
    int   c0;
    reset = 1'b0;
    c_req = 1'b0; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
    #12;
    chk("rst_outs", {26'b0, c_gnt, c_done, l_gnt, l_done, m_re, m_we}, 32'h0);
    chk("rst_bus", m_addr | m_wdata, 32'h0);
    chk("rst_rdata", c_rdata | l_rdata, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk); #1;
    reset = 1'b1;

    // Tie right after reset: core wins in both builds.
    issue(1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, -1);
    issue(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, -1);
    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1);
    issue(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2);
    // Repeated tie after a core grant: loader first under round-robin.
    issue(1'b1, 1'b1, 32'h30, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h34, 32'h0, -1);

    // Reset in the second access cycle of a core write aborts it.
    @(negedge clk); #1;
    c0 = cyc;
    e.id = 1'b0; e.we = 1'b1; e.addr = 32'h70; e.wdata = 32'hCAFE_0001;
    e.c_rd = mc; e.l_rd = ml; e.cy = c0 + 1;
    gq.push_back(e);
    e.cy = c0 + 1 + LAT;
    dq.push_back(e);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h70; c_wdata = 32'hCAFE_0001;
    @(negedge clk); #1;
    c_req = 1'b0;
    @(negedge clk);
    chk("pre_rst_m_we", {31'b0, m_we}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_m_we", {31'b0, m_we}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_done", {30'b0, c_done, l_done}, 32'h0);
    chk("abort_rdata", c_rdata | l_rdata, 32'h0);
    mc = 32'h0; ml = 32'h0; tb_last = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", {30'b0, busy, c_done}, 32'h0);

    issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1);

    repeat (2) @(negedge clk);
    chk("gq_empty", 32'(gq.size()), 32'd0);
    chk("dq_empty", 32'(dq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
